alu_seq_ctrl: RTL and testbench

Hardware microstep sequencer that executes one register-register ALU instruction on the datapath. It drives the same control strobes the datapath already accepts: the PC/MAR/MDR/IR/Y/Z/HI/LO enables and the one-hot register in/out vectors. Fetch, decode and execute run through T0..T6 in hardware, with a memory-ready wait state. It generalises the hand-sequenced T0–T5 add flow in three ways: the register file size is parameterised, MUL/DIV have a two-cycle HI/LO writeback, and illegal opcodes are reported.

---
 rtl/alu_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Microstep sequencer for one register-register ALU instruction. It runs
// fetch, decode and execute as states T0..T6 and drives the control strobes
// that the existing datapath already accepts.
//
// Ports
//   i_clk         single clock, all state changes on the rising edge
//   i_clear       synchronous active-high reset, overrides every other input
//   i_start       request one instruction; only looked at while idle
//   i_mem_ready   memory read data valid; holds the sequencer in T1 when low
//   i_ir          IR contents {opcode, ra, rb, rc, unused}, MSB aligned
//   o_busy        high in every state except idle
//   o_done        one-cycle pulse in the final writeback cycle
//   o_illegal     one-cycle pulse in T3 when the opcode is out of range
//   o_PCout .. o_LOin  single-bit datapath strobes
//   o_Rin, o_Rout one-hot register-file enables, zero when unused
//   o_alu_op      ALU operation select, valid from T4 to the final state
module alu_seq_ctrl #(
  parameter int REG_W = 4,
  parameter int OP_W = 5,
  parameter logic [OP_W-1:0] MUL_OPCODE = 5'b01110,
  parameter logic [OP_W-1:0] DIV_OPCODE = 5'b01111,
  parameter logic [OP_W-1:0] MAX_ALU_OPCODE = 5'b10001,
  localparam int NUM_REGS = 2 ** REG_W
) (
  input  logic                i_clk,
  input  logic                i_clear,
  input  logic                i_start,
  input  logic                i_mem_ready,
  input  logic [31:0]         i_ir,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_illegal,
  output logic                o_PCout,
  output logic                o_MARin,
  output logic                o_IncPC,
  output logic                o_PCin,
  output logic                o_Read,
  output logic                o_MDRin,
  output logic                o_MDRout,
  output logic                o_IRin,
  output logic                o_Yin,
  output logic                o_Zin,
  output logic                o_Zlowout,
  output logic                o_Zhighout,
  output logic                o_HIin,
  output logic                o_LOin,
  output logic [NUM_REGS-1:0] o_Rin,
  output logic [NUM_REGS-1:0] o_Rout,
  output logic [OP_W-1:0]     o_alu_op
);

  localparam int SPARE_W = 32 - OP_W - 3 * REG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [OP_W-1:0]  w_opcode;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic [REG_W-1:0] w_rc;
  logic             w_isMulDiv;
  logic             w_isIllegal;
  logic             w_unusedIrBits;

  // Instruction fields are taken straight from the IR; the datapath keeps
  // the IR stable from T3 until the instruction retires.
  assign w_opcode    = i_ir[31 -: OP_W];
  assign w_ra        = i_ir[31-OP_W -: REG_W];
  assign w_rb        = i_ir[31-OP_W-REG_W -: REG_W];
  assign w_rc        = i_ir[31-OP_W-2*REG_W -: REG_W];
  assign w_isMulDiv  = (w_opcode == MUL_OPCODE) || (w_opcode == DIV_OPCODE);
  assign w_isIllegal = (w_opcode > MAX_ALU_OPCODE);

  // The low IR bits carry no meaning for this instruction format.
  assign w_unusedIrBits = &{1'b0, i_ir[SPARE_W-1:0]};

  function automatic logic [NUM_REGS-1:0] oneHot(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // State register; clear wins over everything and lands in idle.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode. Outputs come from the registered state and
  // the IR fields, except PCin in T1, which waits for the memory handshake so
  // the PC is loaded exactly once however long the read stalls.
  always_comb begin
    w_next     = r_state;
    o_busy     = (r_state != S_IDLE);
    o_done     = 1'b0;
    o_illegal  = 1'b0;
    o_PCout    = 1'b0;
    o_MARin    = 1'b0;
    o_IncPC    = 1'b0;
    o_PCin     = 1'b0;
    o_Read     = 1'b0;
    o_MDRin    = 1'b0;
    o_MDRout   = 1'b0;
    o_IRin     = 1'b0;
    o_Yin      = 1'b0;
    o_Zin      = 1'b0;
    o_Zlowout  = 1'b0;
    o_Zhighout = 1'b0;
    o_HIin     = 1'b0;
    o_LOin     = 1'b0;
    o_Rin      = '0;
    o_Rout     = '0;
    o_alu_op   = '0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_T0;
        end
      end
      S_T0: begin
        o_PCout = 1'b1;
        o_MARin = 1'b1;
        o_IncPC = 1'b1;
        o_Zin   = 1'b1;
        w_next  = S_T1;
      end
      S_T1: begin
        o_Zlowout = 1'b1;
        o_Read    = 1'b1;
        o_MDRin   = 1'b1;
        if (i_mem_ready) begin
          o_PCin = 1'b1;
          w_next = S_T2;
        end
      end
      S_T2: begin
        o_MDRout = 1'b1;
        o_IRin   = 1'b1;
        w_next   = S_T3;
      end
      S_T3: begin
        o_Rout = oneHot(w_rb);
        o_Yin  = 1'b1;
        if (w_isIllegal) begin
          o_illegal = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_T4;
        end
      end
      S_T4: begin
        o_Rout   = oneHot(w_rc);
        o_alu_op = w_opcode;
        o_Zin    = 1'b1;
        w_next   = S_T5;
      end
      S_T5: begin
        o_Zlowout = 1'b1;
        o_alu_op  = w_opcode;
        if (w_isMulDiv) begin
          o_LOin = 1'b1;
          w_next = S_T6;
        end else begin
          o_Rin  = oneHot(w_ra);
          o_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_T6: begin
        o_Zhighout = 1'b1;
        o_HIin     = 1'b1;
        o_alu_op   = w_opcode;
        o_done     = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. Each instruction pushes the per-cycle
// expected strobe picture into a scoreboard queue; every clock cycle one
// entry is popped and compared against the DUT outputs on the falling edge.
module tb_alu_seq_ctrl;

  localparam int B_BUSY = 16;
  localparam int B_DONE = 15;
  localparam int B_ILL = 14;
  localparam int B_PCOUT = 13;
  localparam int B_MARIN = 12;
  localparam int B_INCPC = 11;
  localparam int B_PCIN = 10;
  localparam int B_READ = 9;
  localparam int B_MDRIN = 8;
  localparam int B_MDROUT = 7;
  localparam int B_IRIN = 6;
  localparam int B_YIN = 5;
  localparam int B_ZIN = 4;
  localparam int B_ZLO = 3;
  localparam int B_ZHI = 2;
  localparam int B_HIIN = 1;
  localparam int B_LOIN = 0;

  typedef struct {
    logic [16:0] ctl;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  aluOp;
  } exp_t;

  logic        clk;
  logic        clear;
  logic        start;
  logic        memReady;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  aluOp;
  logic [16:0] obsCtl;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq_ctrl dut (
    .i_clk       (clk),
    .i_clear     (clear),
    .i_start     (start),
    .i_mem_ready (memReady),
    .i_ir        (ir),
    .o_busy      (busy),
    .o_done      (done),
    .o_illegal   (illegal),
    .o_PCout     (PCout),
    .o_MARin     (MARin),
    .o_IncPC     (IncPC),
    .o_PCin      (PCin),
    .o_Read      (Read),
    .o_MDRin     (MDRin),
    .o_MDRout    (MDRout),
    .o_IRin      (IRin),
    .o_Yin       (Yin),
    .o_Zin       (Zin),
    .o_Zlowout   (Zlowout),
    .o_Zhighout  (Zhighout),
    .o_HIin      (HIin),
    .o_LOin      (LOin),
    .o_Rin       (Rin),
    .o_Rout      (Rout),
    .o_alu_op    (aluOp)
  );

  assign obsCtl = {busy, done, illegal, PCout, MARin, IncPC, PCin, Read,
                   MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic pushExp(input logic [16:0] ctl, input logic [15:0] rin,
                         input logic [15:0] rout, input logic [4:0] op);
    exp_t e;
    e.ctl = ctl;
    e.rin = rin;
    e.rout = rout;
    e.aluOp = op;
    sbQ.push_back(e);
  endtask

  task automatic pushIdle();
    pushExp(17'h0, 16'h0, 16'h0, 5'd0);
  endtask

  // Pops one expected cycle and compares all output groups.
  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sbQ.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard empty: observed ctl=%h expected an entry", tag, obsCtl);
    end
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checks++;
      assert (obsCtl === e.ctl) else begin
        errors++;
        $error("[TB] FAIL %s ctl observed=%h expected=%h", tag, obsCtl, e.ctl);
      end
      checks++;
      assert (Rin === e.rin) else begin
        errors++;
        $error("[TB] FAIL %s Rin observed=%h expected=%h", tag, Rin, e.rin);
      end
      checks++;
      assert (Rout === e.rout) else begin
        errors++;
        $error("[TB] FAIL %s Rout observed=%h expected=%h", tag, Rout, e.rout);
      end
      checks++;
      assert (aluOp === e.aluOp) else begin
        errors++;
        $error("[TB] FAIL %s alu_op observed=%0d expected=%0d", tag, aluOp, e.aluOp);
      end
    end
  endtask

  // One clock cycle: inputs for the new cycle are applied just after the
  // rising edge and the outputs are checked on the falling edge.
  task automatic applyStimulus(input bit st, input bit mr, input bit clr, input string tag);
    @(posedge clk);
    #1;
    start = st;
    memReady = mr;
    clear = clr;
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idleTick(input string tag);
    pushIdle();
    applyStimulus(1'b0, 1'b1, 1'b0, tag);
  endtask

  // Runs one instruction starting from an idle cycle in which start is raised.
  task automatic runInstr(input logic [31:0] irv, input int opc, input int ra,
                          input int rb, input int rc, input int waits,
                          input bit pokeT2, input bit holdEnd, input string name);
    logic [16:0] c;
    bit isIll;
    bit isMd;
    isIll = (opc > 17);
    isMd = (opc == 14) || (opc == 15);
    ir = irv;

    pushIdle();
    c = '0; c[B_BUSY] = 1; c[B_PCOUT] = 1; c[B_MARIN] = 1; c[B_INCPC] = 1; c[B_ZIN] = 1;
    pushExp(c, 16'h0, 16'h0, 5'd0);
    for (int i = 0; i <= waits; i++) begin
      c = '0; c[B_BUSY] = 1; c[B_ZLO] = 1; c[B_READ] = 1; c[B_MDRIN] = 1;
      c[B_PCIN] = (i == waits);
      pushExp(c, 16'h0, 16'h0, 5'd0);
    end
    c = '0; c[B_BUSY] = 1; c[B_MDROUT] = 1; c[B_IRIN] = 1;
    pushExp(c, 16'h0, 16'h0, 5'd0);
    c = '0; c[B_BUSY] = 1; c[B_YIN] = 1; c[B_ILL] = isIll;
    pushExp(c, 16'h0, 16'(1) << rb, 5'd0);
    if (!isIll) begin
      c = '0; c[B_BUSY] = 1; c[B_ZIN] = 1;
      pushExp(c, 16'h0, 16'(1) << rc, 5'(opc));
      if (isMd) begin
        c = '0; c[B_BUSY] = 1; c[B_ZLO] = 1; c[B_LOIN] = 1;
        pushExp(c, 16'h0, 16'h0, 5'(opc));
        c = '0; c[B_BUSY] = 1; c[B_ZHI] = 1; c[B_HIIN] = 1; c[B_DONE] = 1;
        pushExp(c, 16'h0, 16'h0, 5'(opc));
      end else begin
        c = '0; c[B_BUSY] = 1; c[B_ZLO] = 1; c[B_DONE] = 1;
        pushExp(c, 16'(1) << ra, 16'h0, 5'(opc));
      end
    end

    applyStimulus(1'b1, 1'b1, 1'b0, {name, "-start"});
    applyStimulus(1'b0, 1'b1, 1'b0, {name, "-T0"});
    for (int i = 0; i < waits; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, {name, "-T1wait"});
    end
    applyStimulus(1'b0, 1'b1, 1'b0, {name, "-T1"});
    applyStimulus(pokeT2, 1'b1, 1'b0, {name, "-T2"});
    applyStimulus(1'b0, 1'b1, 1'b0, {name, "-T3"});
    if (!isIll) begin
      applyStimulus(1'b0, 1'b1, 1'b0, {name, "-T4"});
      if (isMd) begin
        applyStimulus(1'b0, 1'b1, 1'b0, {name, "-T5"});
        applyStimulus(holdEnd, 1'b1, 1'b0, {name, "-T6"});
      end else begin
        applyStimulus(holdEnd, 1'b1, 1'b0, {name, "-T5"});
      end
    end
  endtask

  function automatic logic [31:0] mkIr(input int opc, input int ra, input int rb, input int rc);
    return {5'(opc), 4'(ra), 4'(rb), 4'(rc), 15'h0};
  endfunction

  initial begin
    logic [16:0] c;
    clear = 1'b1;
    start = 1'b0;
    memReady = 1'b1;
    ir = 32'h0;

    $display("[TB] reset");
    pushIdle();
    applyStimulus(1'b0, 1'b1, 1'b1, "reset");
    idleTick("postReset");

    $display("[TB] ADD with no memory wait");
    runInstr(32'h28918000, 5, 1, 2, 3, 0, 1'b0, 1'b0, "add");
    idleTick("add-after");

    $display("[TB] ADD with three memory wait cycles");
    runInstr(32'h28918000, 5, 1, 2, 3, 3, 1'b0, 1'b0, "addWait");
    idleTick("addWait-after");

    $display("[TB] MUL and DIV");
    runInstr(mkIr(14, 4, 5, 6), 14, 4, 5, 6, 0, 1'b0, 1'b0, "mul");
    idleTick("mul-after");
    runInstr(mkIr(15, 9, 10, 11), 15, 9, 10, 11, 1, 1'b0, 1'b0, "div");
    idleTick("div-after");

    $display("[TB] opcode range boundaries");
    runInstr(mkIr(17, 15, 0, 7), 17, 15, 0, 7, 0, 1'b0, 1'b0, "maxLegal");
    idleTick("maxLegal-after");
    runInstr(mkIr(18, 2, 3, 4), 18, 2, 3, 4, 0, 1'b0, 1'b0, "ill18");
    idleTick("ill18-k5");
    runInstr(mkIr(31, 1, 2, 3), 31, 1, 2, 3, 0, 1'b0, 1'b0, "ill31");
    idleTick("ill31-k5");

    $display("[TB] same register for ra rb rc");
    runInstr(mkIr(3, 7, 7, 7), 3, 7, 7, 7, 0, 1'b0, 1'b0, "sameReg");
    idleTick("sameReg-after");

    $display("[TB] back-to-back with start ignored while busy");
    runInstr(mkIr(1, 12, 13, 14), 1, 12, 13, 14, 0, 1'b1, 1'b1, "b2bFirst");
    runInstr(mkIr(2, 5, 6, 8), 2, 5, 6, 8, 0, 1'b1, 1'b0, "b2bSecond");
    idleTick("b2b-after1");
    idleTick("b2b-after2");

    $display("[TB] clear during T4 of ADD");
    ir = 32'h28918000;
    pushIdle();
    c = '0; c[B_BUSY] = 1; c[B_PCOUT] = 1; c[B_MARIN] = 1; c[B_INCPC] = 1; c[B_ZIN] = 1;
    pushExp(c, 16'h0, 16'h0, 5'd0);
    c = '0; c[B_BUSY] = 1; c[B_ZLO] = 1; c[B_READ] = 1; c[B_MDRIN] = 1; c[B_PCIN] = 1;
    pushExp(c, 16'h0, 16'h0, 5'd0);
    c = '0; c[B_BUSY] = 1; c[B_MDROUT] = 1; c[B_IRIN] = 1;
    pushExp(c, 16'h0, 16'h0, 5'd0);
    c = '0; c[B_BUSY] = 1; c[B_YIN] = 1;
    pushExp(c, 16'h0, 16'h0004, 5'd0);
    c = '0; c[B_BUSY] = 1; c[B_ZIN] = 1;
    pushExp(c, 16'h0, 16'h0008, 5'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, "clr-start");
    applyStimulus(1'b0, 1'b1, 1'b0, "clr-T0");
    applyStimulus(1'b0, 1'b1, 1'b0, "clr-T1");
    applyStimulus(1'b0, 1'b1, 1'b0, "clr-T2");
    applyStimulus(1'b0, 1'b1, 1'b0, "clr-T3");
    applyStimulus(1'b0, 1'b1, 1'b1, "clr-T4");
    pushIdle();
    applyStimulus(1'b1, 1'b1, 1'b1, "clr-hold");
    idleTick("clr-idle1");
    idleTick("clr-idle2");

    $display("[TB] run after clear");
    runInstr(mkIr(0, 0, 15, 1), 0, 0, 15, 1, 0, 1'b0, 1'b0, "afterClr");
    idleTick("afterClr-after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
